// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: 4-wire SPI responder that turns CSX/DCX/SCK/SDI into DCX-tagged bytes queued in a polled FIFO
module lcd_spi_rx #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SCK,
    input  logic        SDI,
    input  logic        CSX,
    input  logic        DCX,
    input  logic        pop,
    input  logic        clr,
    output logic [15:0] out
);
    localparam int AW = $clog2(DEPTH);

    logic [SYNC_STAGES-1:0] sck_sr, sdi_sr, csx_sr, dcx_sr, live_sr;
    logic                   sck_q, csx_q, armed;
    logic                   sck_s, sdi_s, csx_s, dcx_s, live;
    logic                   active, sck_rise, csx_rise, byte_done;
    logic [2:0]             cnt;
    logic [6:0]             shift_reg;
    logic [8:0]             mem [DEPTH];
    logic [AW-1:0]          wp, rp;
    logic [AW:0]            count;
    logic                   ovf, ferr, full, do_pop, do_push, ovf_ev, ferr_ev, valid;

    assign sck_s     = sck_sr[SYNC_STAGES-1];
    assign sdi_s     = sdi_sr[SYNC_STAGES-1];
    assign csx_s     = csx_sr[SYNC_STAGES-1];
    assign dcx_s     = dcx_sr[SYNC_STAGES-1];
    // live marks that the last sync stage now holds a real sample rather than its reset value
    assign live      = live_sr[SYNC_STAGES-1];
    assign active    = armed & ~csx_s;
    assign sck_rise  = active & sck_s & ~sck_q;
    assign csx_rise  = csx_s & ~csx_q;
    assign byte_done = sck_rise & (cnt == 3'd7);
    assign ferr_ev   = csx_rise & (cnt != 3'd0);
    assign full      = count == (AW+1)'(DEPTH);
    assign do_pop    = pop & (count != '0);
    assign do_push   = byte_done & (~full | do_pop);
    assign ovf_ev    = byte_done & full & ~do_pop;
    assign valid     = count != '0;
    assign out       = {valid, ovf, ferr, ~csx_s & (cnt != 3'd0), 3'b000, valid ? mem[rp] : 9'h000};

    // input synchronizers plus edge-detect history on SCK and CSX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sr  <= '0;
            sdi_sr  <= '0;
            csx_sr  <= '1;
            dcx_sr  <= '0;
            live_sr <= '0;
            sck_q   <= 1'b0;
            csx_q   <= 1'b1;
        end else begin
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], SCK};
            sdi_sr  <= {sdi_sr[SYNC_STAGES-2:0], SDI};
            csx_sr  <= {csx_sr[SYNC_STAGES-2:0], CSX};
            dcx_sr  <= {dcx_sr[SYNC_STAGES-2:0], DCX};
            live_sr <= {live_sr[SYNC_STAGES-2:0], 1'b1};
            sck_q   <= sck_s;
            csx_q   <= csx_s;
        end
    end

    // bit capture; reception arms only after a real CSX-high sample, so a frame cut by reset is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            cnt       <= 3'd0;
            shift_reg <= 7'd0;
        end else begin
            armed <= armed | (live & csx_s);
            if (!active) begin
                cnt       <= 3'd0;
                shift_reg <= 7'd0;
            end else if (sck_rise) begin
                cnt       <= cnt + 3'd1;
                shift_reg <= {shift_reg[5:0], sdi_s};
            end
        end
    end

    // FIFO storage, written with the completed byte and its DCX tag
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= {dcx_s, shift_reg, sdi_s};
    end

    // FIFO pointers, occupancy and sticky error flags (a new event beats clr)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            ovf   <= (ovf & ~clr) | ovf_ev;
            ferr  <= (ferr & ~clr) | ferr_ev;
        end
    end
endmodule
